// File: rtl/soc_irq_timer_if.sv
// rtl/soc_irq_timer_if.sv - data-memory bus bundle shared by the CPU and the timer/irq block
interface soc_irq_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        hit;

    modport master (output ce, output we, output addr, output wtData,
                    input  rdData, input hit);
    modport slave  (input  ce, input we, input addr, input wtData,
                    output rdData, output hit);
endinterface

// File: rtl/soc_irq_timer.sv
// rtl/soc_irq_timer.sv - timer bank and interrupt aggregator on the data-memory bus
// Timers at 0x10*t, PEND at 0x40, MASK at 0x44; window spans 128 bytes from BASE_ADDR.
module soc_irq_timer #(
    parameter int          NUM_TIMERS = 2,
    parameter int          NUM_EXT    = 2,
    parameter int          INTR_W     = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          PRESCALE   = 1,
    localparam int         EXT_W      = (NUM_EXT > 0) ? NUM_EXT : 1
) (
    input  logic              clk,
    input  logic              rst,
    soc_irq_timer_if.slave    bus,
    input  logic [EXT_W-1:0]  ext_irq,
    output logic [INTR_W-1:0] intr
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [31:0] offset;
    logic [4:0]  wordIdx;
    logic [1:0]  timerSel;
    logic [1:0]  regSel;
    logic        inTimers;
    logic        isPend;
    logic        isMask;
    logic        wrEn;

    assign offset   = bus.addr - BASE_ADDR;
    assign bus.hit  = bus.ce && (offset < 32'h80);
    assign wordIdx  = offset[6:2];
    assign timerSel = wordIdx[3:2];
    assign regSel   = wordIdx[1:0];
    assign inTimers = ~wordIdx[4];
    assign isPend   = (wordIdx == 5'h10);
    assign isMask   = (wordIdx == 5'h11);
    assign wrEn     = bus.hit && bus.we;

    logic [PW-1:0] preCnt;
    logic          tick;

    assign tick = (preCnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preCnt <= '0;
        end else if (tick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + 1'b1;
        end
    end

    logic [NUM_TIMERS-1:0] ctrlEn;
    logic [NUM_TIMERS-1:0] ctrlAuto;
    logic [NUM_TIMERS-1:0] ctrlIe;
    logic [NUM_TIMERS-1:0] flag;
    logic [31:0]           loadReg  [NUM_TIMERS];
    logic [31:0]           countReg [NUM_TIMERS];

    logic [NUM_TIMERS-1:0] wrCtrl;
    logic [NUM_TIMERS-1:0] wrLoad;
    logic [NUM_TIMERS-1:0] wrCount;
    logic [NUM_TIMERS-1:0] wrStat;
    logic [NUM_TIMERS-1:0] tickUpd;
    logic [NUM_TIMERS-1:0] expire;

    always_comb begin
        wrCtrl  = '0;
        wrLoad  = '0;
        wrCount = '0;
        wrStat  = '0;
        for (int t = 0; t < NUM_TIMERS; t++) begin
            if (wrEn && inTimers && (timerSel == 2'(t))) begin
                case (regSel)
                    2'd0:    wrCtrl[t]  = 1'b1;
                    2'd1:    wrLoad[t]  = 1'b1;
                    2'd2:    wrCount[t] = 1'b1;
                    default: wrStat[t]  = 1'b1;
                endcase
            end
        end
    end

    // A bus write to CTRL or COUNT takes priority over that timer's tick update.
    always_comb begin
        tickUpd = '0;
        expire  = '0;
        for (int t = 0; t < NUM_TIMERS; t++) begin
            tickUpd[t] = tick && ctrlEn[t] && !wrCtrl[t] && !wrCount[t];
            expire[t]  = tickUpd[t] && (countReg[t] == 32'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlEn   <= '0;
            ctrlAuto <= '0;
            ctrlIe   <= '0;
            flag     <= '0;
            for (int t = 0; t < NUM_TIMERS; t++) begin
                loadReg[t]  <= '0;
                countReg[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TIMERS; t++) begin
                if (wrCtrl[t]) begin
                    ctrlEn[t]   <= bus.wtData[0];
                    ctrlAuto[t] <= bus.wtData[1];
                    ctrlIe[t]   <= bus.wtData[2];
                end else if (expire[t] && !ctrlAuto[t]) begin
                    ctrlEn[t] <= 1'b0;
                end

                if (wrLoad[t]) begin
                    loadReg[t] <= bus.wtData;
                end

                if (wrCount[t]) begin
                    countReg[t] <= bus.wtData;
                end else if (expire[t]) begin
                    if (ctrlAuto[t]) begin
                        countReg[t] <= loadReg[t];
                    end
                end else if (tickUpd[t]) begin
                    countReg[t] <= countReg[t] - 32'd1;
                end

                // Expiry wins over a same-cycle W1C so no event is lost.
                if (expire[t]) begin
                    flag[t] <= 1'b1;
                end else if (wrStat[t] && bus.wtData[0]) begin
                    flag[t] <= 1'b0;
                end
            end
        end
    end

    logic [EXT_W-1:0] sync1;
    logic [EXT_W-1:0] sync2;
    logic [EXT_W-1:0] extPrev;
    logic [EXT_W-1:0] extPend;
    logic [EXT_W-1:0] extRise;
    logic [EXT_W-1:0] extClr;

    assign extRise = sync2 & ~extPrev;
    assign extClr  = (wrEn && isPend) ? bus.wtData[NUM_TIMERS +: EXT_W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            extPrev <= '0;
            extPend <= '0;
        end else begin
            sync1   <= ext_irq;
            sync2   <= sync1;
            extPrev <= sync2;
            extPend <= extRise | (extPend & ~extClr);
        end
    end

    logic [INTR_W-1:0] pend;
    logic [INTR_W-1:0] maskReg;

    for (genvar i = 0; i < INTR_W; i++) begin : g_pend
        if (i < NUM_TIMERS) begin : g_tmr
            assign pend[i] = flag[i] & ctrlIe[i];
        end else if (i < NUM_TIMERS + NUM_EXT) begin : g_ext
            assign pend[i] = extPend[i - NUM_TIMERS];
        end else begin : g_zero
            assign pend[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maskReg <= '0;
            intr    <= '0;
        end else begin
            if (wrEn && isMask) begin
                maskReg <= bus.wtData[INTR_W-1:0];
            end
            intr <= pend & maskReg;
        end
    end

    logic [31:0] rdMux;

    always_comb begin
        rdMux = '0;
        if (bus.hit) begin
            if (inTimers) begin
                for (int t = 0; t < NUM_TIMERS; t++) begin
                    if (timerSel == 2'(t)) begin
                        case (regSel)
                            2'd0:    rdMux = {29'd0, ctrlIe[t], ctrlAuto[t], ctrlEn[t]};
                            2'd1:    rdMux = loadReg[t];
                            2'd2:    rdMux = countReg[t];
                            default: rdMux = {31'd0, flag[t]};
                        endcase
                    end
                end
            end else if (isPend) begin
                rdMux = 32'(pend);
            end else if (isMask) begin
                rdMux = 32'(maskReg);
            end
        end
    end

    assign bus.rdData = rdMux;

endmodule

// File: tb/tb_soc_irq_timer.sv
// tb/tb_soc_irq_timer.sv - directed bench for soc_irq_timer
module tb_soc_irq_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] extIrq = 2'b00;
    logic [5:0] intr;

    int errors = 0;
    int checks = 0;
    int seq [6] = '{2, 1, 0, 2, 1, 0};

    soc_irq_timer_if bus ();

    soc_irq_timer #(
        .NUM_TIMERS(2),
        .NUM_EXT   (2),
        .INTR_W    (6),
        .BASE_ADDR (BASE),
        .PRESCALE  (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ext_irq(extIrq),
        .intr   (intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        bus.ce     = 1'b1;
        bus.we     = 1'b1;
        bus.addr   = BASE + off;
        bus.wtData = d;
        cyc();
        bus.ce = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        bus.ce   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = BASE + off;
        #1;
        d = bus.rdData;
        bus.ce = 1'b0;
    endtask

    task automatic chkRd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        chk(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n;

        bus.ce = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wtData = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_intr", 32'(intr), 32'h0);
        chkRd("rst_ctrl0", 32'h00, 32'h0);
        chkRd("rst_pend", 32'h40, 32'h0);
        rst = 1'b1;
        cyc();

        bus.addr = BASE + 32'h44;
        bus.ce = 1'b0;
        #1;
        chk("noce_hit", 32'(bus.hit), 32'h0);
        chk("noce_rd", bus.rdData, 32'h0);

        // One-shot: COUNT=3 expires on the 4th tick after enable
        wr(32'h44, 32'h1);
        wr(32'h08, 32'd3);
        wr(32'h00, 32'h5);
        chkRd("os_cnt_start", 32'h08, 32'd3);
        repeat (3) cyc();
        chkRd("os_cnt_zero", 32'h08, 32'd0);
        chkRd("os_flag_pre", 32'h0C, 32'd0);
        cyc();
        chkRd("os_flag", 32'h0C, 32'd1);
        chk("os_intr_lag", 32'(intr), 32'h0);
        chkRd("os_ctrl", 32'h00, 32'h4);
        cyc();
        chk("os_intr", 32'(intr), 32'h1);
        wr(32'h0C, 32'h1);
        chkRd("os_flag_clr", 32'h0C, 32'd0);
        chk("os_intr_hold", 32'(intr), 32'h1);
        cyc();
        chk("os_intr_clr", 32'(intr), 32'h0);

        // Auto-reload: period LOAD+1 = 3 ticks
        wr(32'h04, 32'd2);
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h7);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            chkRd($sformatf("ar_cnt%0d", i), 32'h08, 32'(seq[i]));
            if (i == 2) chkRd("ar_flag_pre", 32'h0C, 32'd0);
            if (i == 3) chkRd("ar_flag", 32'h0C, 32'd1);
        end

        // Collisions: W1C on an expiry cycle, COUNT write on a tick cycle
        wr(32'h0C, 32'h1);
        chkRd("col_flag", 32'h0C, 32'd1);
        chkRd("col_reload", 32'h08, 32'd2);
        wr(32'h0C, 32'h1);
        chkRd("col_flag_clr", 32'h0C, 32'd0);
        wr(32'h08, 32'd9);
        chkRd("col_cnt_wr", 32'h08, 32'd9);
        cyc();
        chkRd("col_cnt_dec", 32'h08, 32'd8);
        wr(32'h00, 32'h0);
        wr(32'h0C, 32'h1);
        cyc();
        chk("ar_idle_intr", 32'(intr), 32'h0);

        // External interrupt, masked through
        wr(32'h44, 32'h3F);
        extIrq[0] = 1'b1;
        cyc();
        extIrq[0] = 1'b0;
        n = 1;
        rd(32'h40, d);
        while (!d[2] && n < 6) begin
            cyc();
            n++;
            rd(32'h40, d);
        end
        chk("ext_pend", d, 32'h4);
        chk("ext_lat", 32'(n <= 3), 32'h1);
        cyc();
        chk("ext_intr", 32'(intr), 32'h4);
        wr(32'h40, 32'h4);
        chkRd("ext_clr", 32'h40, 32'h0);
        cyc();
        chk("ext_intr_clr", 32'(intr), 32'h0);

        // External interrupt, masked off; level held does not re-pend
        wr(32'h44, 32'h0);
        extIrq[1] = 1'b1;
        repeat (4) cyc();
        chkRd("ext_nomask_pend", 32'h40, 32'h8);
        chk("ext_nomask_intr", 32'(intr), 32'h0);
        wr(32'h40, 32'h8);
        repeat (3) cyc();
        chkRd("ext_level_noreset", 32'h40, 32'h0);
        extIrq[1] = 1'b0;
        repeat (3) cyc();

        // Decode
        wr(32'h50, 32'hFFFF_FFFF);
        chkRd("dec_unmapped", 32'h50, 32'h0);
        chkRd("dec_mask_kept", 32'h44, 32'h0);
        chkRd("dec_ctrl0_kept", 32'h00, 32'h0);
        bus.ce = 1'b1;
        bus.we = 1'b0;
        bus.addr = BASE + 32'h100;
        #1;
        chk("dec_out_hi_hit", 32'(bus.hit), 32'h0);
        chk("dec_out_hi_rd", bus.rdData, 32'h0);
        bus.addr = BASE - 32'd4;
        #1;
        chk("dec_out_lo_hit", 32'(bus.hit), 32'h0);
        chk("dec_out_lo_rd", bus.rdData, 32'h0);
        bus.ce = 1'b0;

        // Reset while running
        wr(32'h44, 32'h3F);
        wr(32'h08, 32'd1000);
        wr(32'h00, 32'h1);
        wr(32'h14, 32'd0);
        wr(32'h18, 32'd0);
        wr(32'h10, 32'h7);
        repeat (3) cyc();
        chk("pre_rst_intr", 32'(intr), 32'h2);
        rd(32'h08, d);
        chk("pre_rst_cnt0_running", 32'(d != 32'd0), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_intr", 32'(intr), 32'h0);
        chkRd("mid_rst_cnt0", 32'h08, 32'h0);
        chkRd("mid_rst_ctrl1", 32'h10, 32'h0);
        chkRd("mid_rst_stat1", 32'h1C, 32'h0);
        chkRd("mid_rst_mask", 32'h44, 32'h0);
        chkRd("mid_rst_pend", 32'h40, 32'h0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("post_rst_intr", 32'(intr), 32'h0);
        chkRd("post_rst_cnt0", 32'h08, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_irq_timer.md
Name: soc_irq_timer

Overview:
Memory-mapped timer bank and interrupt aggregator that drives the CPU's 6-bit intr vector, replacing the fixed {5'b0, timer} wiring at SoC level. It provides NUM_TIMERS down-counting timers, NUM_EXT synchronised external interrupt lines, and pending/mask registers. It sits on the data-memory bus beside DataMem, uses the same ce/we/addr/wtData/rdData signals, and is selected by address decode on BASE_ADDR.

Parameters:
NUM_TIMERS, 2, number of timers (1..4)
NUM_EXT, 2, number of external interrupt inputs (0..4); NUM_TIMERS+NUM_EXT <= INTR_W
INTR_W, 6, width of intr output
BASE_ADDR, 32'h1000_0000, byte base address of the register window (64-byte aligned)
PRESCALE, 1, clk cycles per timer tick (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
ce  in  1  bus chip enable (memCe)
we  in  1  bus write enable (memWr), qualified by ce
addr  in  32  bus byte address
wtData  in  32  write data
rdData  out  32  read data
hit  out  1  addr within window and ce=1; SoC read-mux select against DataMem
ext_irq  in  NUM_EXT  asynchronous level interrupt sources
intr  out  INTR_W  interrupt vector to CPU

Behaviour:
- Register map, offset = addr - BASE_ADDR, word aligned; addr[1:0] ignored. Timer t at 0x10*t: +0x0 CTRL (bit0 EN, bit1 AUTO, bit2 IE), +0x4 LOAD[31:0], +0x8 COUNT[31:0] (read current value; write loads it), +0xC STAT (bit0 FLAG; write 1 clears). Global: 0x40 PEND (bits [NUM_TIMERS-1:0]=timer FLAG&IE, next NUM_EXT bits=ext pending; write 1 clears ext bits, timer bits read-only), 0x44 MASK[INTR_W-1:0] RW.
- Unmapped offsets in the window: read 0, write ignored.
- Reads are combinational, same cycle, so they match DataMem timing. rdData=0 when hit=0. Writes commit on the rising clk edge when ce&we&hit.
- Reset (rst=0, async): all CTRL/LOAD/COUNT/STAT/PEND/MASK=0, prescaler=0, sync flops=0, intr=0. Release is synchronous to the next edge.
- Prescaler: free-running counter 0..PRESCALE-1; tick=1 in the cycle it equals PRESCALE-1. PRESCALE=1 gives tick every cycle.
- Timer on tick with EN=1: if COUNT!=0 then COUNT-=1; if COUNT==0 then FLAG<=1 and, if AUTO, COUNT<=LOAD; else EN<=0. Period is LOAD+1 ticks. LOAD=0 with AUTO fires every tick.
- Simultaneous events: a bus write to COUNT or CTRL beats the tick update in the same cycle. FLAG set and W1C in the same cycle: set wins. Writing CTRL.EN=1 does not reload COUNT; software writes COUNT first.
- Ext lines: 2-flop synchroniser, then rising-edge detect sets the PEND ext bit, which holds until W1C. An edge coinciding with a clear leaves the bit set. Level-high after clear does not re-set.
- intr[i] = PEND[i] & MASK[i], registered, so it lags the causing flag edge by 1 clk. Bits >= NUM_TIMERS+NUM_EXT are 0.
- Reset mid-count clears everything immediately; no pending state survives.

Test Plan:
- Reset: rst=0 mid-operation -> intr=0, all reads 0, including COUNT of a running timer; rdData=0 with ce=0.
- One-shot: PRESCALE=1, LOAD ignored, COUNT=3, CTRL=0b101, MASK=1 -> STAT.FLAG=1 on the 4th tick; intr[0]=1 one clk later; CTRL.EN reads 0; W1C STAT -> intr[0]=0 next clk.
- Auto-reload: LOAD=2, COUNT=2, CTRL=0b111 -> FLAG sets every 3 ticks; COUNT sequence 2,1,0,2,1,0.
- Collision: W1C STAT in the same cycle that the timer expires -> FLAG remains 1; write COUNT=9 on a tick cycle -> COUNT reads 9 next cycle.
- Ext irq: pulse ext_irq[0] for 1 clk, MASK=0x3F -> PEND bit NUM_TIMERS set within 3 clks, intr bit 1 clk later; MASK=0 -> PEND set, intr=0; W1C clears.
- Decode: write to BASE_ADDR+0x50 -> no state change, reads 0; addr outside window -> hit=0, rdData=0.
